// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file: pointer byte, then write or read data bytes.
// SCL/SDA are oversampled on wb_clk_i; the target never stretches the clock.
module i2c_slave_regfile #(
   parameter logic [6:0] SADR = 7'b0010000,
   parameter int         AW   = 4
) (
   input  logic          wb_clk_i,
   input  logic          arst_i,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe_o,
   output logic          busy_o,
   output logic          wr_stb_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [7:0]    wr_data_o,
   input  logic [AW-1:0] host_addr_i,
   output logic [7:0]    host_data_o
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ADDR      = 4'd1,
      S_ACK_ADDR  = 4'd2,
      S_PTR       = 4'd3,
      S_ACK_PTR   = 4'd4,
      S_WDATA     = 4'd5,
      S_ACK_WDATA = 4'd6,
      S_RDATA     = 4'd7,
      S_RACK      = 4'd8,
      S_WAIT_STOP = 4'd9
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    scl_sync_q, sda_sync_q;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          rw_q, rw_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          wr_stb_q, wr_stb_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [7:0]    regs_q [DEPTH];

   logic          scl_s, scl_h, sda_s, sda_h;
   logic          scl_rise_s, scl_fall_s, start_s, stop_s;
   logic          last_bit_s, addr_match_s;
   logic [7:0]    byte_in_s, rd_byte_s;

   assign scl_s        = scl_sync_q[1];
   assign scl_h        = scl_sync_q[2];
   assign sda_s        = sda_sync_q[1];
   assign sda_h        = sda_sync_q[2];
   assign scl_rise_s   = scl_s & ~scl_h;
   assign scl_fall_s   = ~scl_s & scl_h;
   assign start_s      = ~sda_s & sda_h & scl_s & scl_h;
   assign stop_s       = sda_s & ~sda_h & scl_s & scl_h;
   assign last_bit_s   = (cnt_q == 3'd7);
   assign byte_in_s    = {shift_q[6:0], sda_s};
   assign addr_match_s = (byte_in_s[7:1] == SADR);
   assign rd_byte_s    = regs_q[ptr_q];

   // Two synchronizer stages plus one history stage; idle bus level is high.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_i};
         sda_sync_q <= {sda_sync_q[1:0], sda_i};
      end
   end

   // FSM state register.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; START/STOP override any bit event in the same cycle.
   always_comb begin
      state_d = state_q;
      if (start_s) begin
         state_d = S_ADDR;
      end else if (stop_s) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      state_d = S_IDLE;
            S_ADDR: begin
               if (scl_rise_s && last_bit_s) begin
                  state_d = addr_match_s ? S_ACK_ADDR : S_WAIT_STOP;
               end else begin
                  state_d = S_ADDR;
               end
            end
            S_ACK_ADDR: begin
               if (scl_fall_s && phase_q) begin
                  state_d = rw_q ? S_RDATA : S_PTR;
               end else begin
                  state_d = S_ACK_ADDR;
               end
            end
            S_PTR: begin
               if (scl_rise_s && last_bit_s) begin
                  state_d = S_ACK_PTR;
               end else begin
                  state_d = S_PTR;
               end
            end
            S_ACK_PTR, S_ACK_WDATA: begin
               if (scl_fall_s && phase_q) begin
                  state_d = S_WDATA;
               end else begin
                  state_d = state_q;
               end
            end
            S_WDATA: begin
               if (scl_rise_s && last_bit_s) begin
                  state_d = S_ACK_WDATA;
               end else begin
                  state_d = S_WDATA;
               end
            end
            S_RDATA: begin
               if (scl_fall_s && last_bit_s) begin
                  state_d = S_RACK;
               end else begin
                  state_d = S_RDATA;
               end
            end
            S_RACK: begin
               if (scl_rise_s && sda_s) begin
                  state_d = S_WAIT_STOP;
               end else if (scl_fall_s && phase_q) begin
                  state_d = S_RDATA;
               end else begin
                  state_d = S_RACK;
               end
            end
            S_WAIT_STOP: state_d = S_WAIT_STOP;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // FSM output/datapath logic: shifting, ACK drive, pointer and write strobe.
   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      rw_d      = rw_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (start_s) begin
         cnt_d    = 3'd0;
         phase_d  = 1'b0;
         sda_oe_d = 1'b0;
      end else if (stop_s) begin
         cnt_d    = 3'd0;
         phase_d  = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (scl_rise_s) begin
                  shift_d = byte_in_s;
                  cnt_d   = cnt_q + 3'd1;
                  if (last_bit_s) begin
                     busy_d  = addr_match_s;
                     rw_d    = addr_match_s ? byte_in_s[0] : rw_q;
                     phase_d = 1'b0;
                  end else begin
                     busy_d = busy_q;
                  end
               end else begin
                  shift_d = shift_q;
               end
            end
            S_PTR, S_WDATA: begin
               if (scl_rise_s) begin
                  shift_d = byte_in_s;
                  cnt_d   = cnt_q + 3'd1;
                  if (last_bit_s && (state_q == S_PTR)) begin
                     ptr_d = byte_in_s[AW-1:0];
                  end else if (last_bit_s) begin
                     wr_stb_d  = 1'b1;
                     wr_addr_d = ptr_q;
                     wr_data_d = byte_in_s;
                     ptr_d     = ptr_q + AW'(1);
                  end else begin
                     ptr_d = ptr_q;
                  end
               end else begin
                  shift_d = shift_q;
               end
            end
            S_ACK_ADDR, S_ACK_PTR, S_ACK_WDATA: begin
               if (scl_fall_s && !phase_q) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 1'b1;
               end else if (scl_fall_s) begin
                  phase_d = 1'b0;
                  cnt_d   = 3'd0;
                  // A read starts by presenting bit 7 on the same fall that ends the ACK.
                  if ((state_q == S_ACK_ADDR) && rw_q) begin
                     shift_d  = rd_byte_s;
                     sda_oe_d = ~rd_byte_s[7];
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            S_RDATA: begin
               if (scl_fall_s && last_bit_s) begin
                  sda_oe_d = 1'b0;
                  ptr_d    = ptr_q + AW'(1);
                  cnt_d    = 3'd0;
                  phase_d  = 1'b0;
               end else if (scl_fall_s) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
                  cnt_d    = cnt_q + 3'd1;
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            S_RACK: begin
               if (scl_rise_s && sda_s) begin
                  busy_d = 1'b0;
               end else if (scl_rise_s) begin
                  phase_d = 1'b1;
               end else if (scl_fall_s && phase_q) begin
                  shift_d  = rd_byte_s;
                  sda_oe_d = ~rd_byte_s[7];
                  cnt_d    = 3'd0;
                  phase_d  = 1'b0;
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            S_IDLE, S_WAIT_STOP: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         shift_q   <= 8'h00;
         cnt_q     <= 3'd0;
         phase_q   <= 1'b0;
         rw_q      <= 1'b0;
         ptr_q     <= '0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'h00;
      end else begin
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         rw_q      <= rw_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Register file commits one cycle after the strobe so a same-cycle host read sees the old byte.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (wr_stb_q) begin
         regs_q[wr_addr_q] <= wr_data_q;
      end else begin
         regs_q[wr_addr_q] <= regs_q[wr_addr_q];
      end
   end

   assign sda_oe_o    = sda_oe_q;
   assign busy_o      = busy_q;
   assign wr_stb_o    = wr_stb_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign host_data_o = regs_q[host_addr_i];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master driving i2c_slave_regfile, checked against a transaction-level register model.
module tb_i2c_slave_regfile;

   localparam int        Q    = 8;
   localparam logic[6:0] SADR = 7'b0010000;

   logic       clk = 1'b0;
   logic       arst;
   logic       scl_m, sda_m;
   logic       sda_line;
   logic       sda_oe, busy, wr_stb;
   logic [3:0] wr_addr, host_addr;
   logic [7:0] wr_data, host_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: register contents and current pointer.
   logic [7:0]  mem [16];
   int          ptr_m;
   logic [11:0] exp_q [$];
   logic [11:0] stb_q [$];
   logic [7:0]  wq [$];
   logic [7:0]  hv_during, hv_after;
   bit          hv_pend, oe_seen, busy_seen;

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_regfile #(.SADR(SADR), .AW(4)) dut (
      .wb_clk_i    (clk),
      .arst_i      (arst),
      .scl_i       (scl_m),
      .sda_i       (sda_line),
      .sda_oe_o    (sda_oe),
      .busy_o      (busy),
      .wr_stb_o    (wr_stb),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data),
      .host_addr_i (host_addr),
      .host_data_o (host_data)
   );

   always #5 clk = ~clk;

   // Strobe and bus monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (hv_pend) begin
         hv_after = host_data;
         hv_pend  = 1'b0;
      end
      if (wr_stb) begin
         stb_q.push_back({wr_addr, wr_data});
         if (wr_addr == host_addr) begin
            hv_during = host_data;
            hv_pend   = 1'b1;
         end
      end
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      write_bit(nack);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) begin
         host_addr = 4'(i);
         #1;
         check_eq(tag, {24'h0, host_data}, {24'h0, mem[i]});
      end
   endtask

   // Write transaction: pointer then the bytes in wq.
   task automatic txn_write(input logic [7:0] p);
      logic ack;
      stb_q.delete();
      exp_q.delete();
      i2c_start();
      write_byte({SADR, 1'b0}, ack); check_eq("w_addr_ack", {31'h0, ack}, 32'h0);
      write_byte(p, ack);            check_eq("w_ptr_ack", {31'h0, ack}, 32'h0);
      ptr_m = p % 16;
      foreach (wq[i]) begin
         write_byte(wq[i], ack);     check_eq("w_data_ack", {31'h0, ack}, 32'h0);
         mem[ptr_m] = wq[i];
         exp_q.push_back({4'(ptr_m), wq[i]});
         ptr_m = (ptr_m + 1) % 16;
      end
      i2c_stop();
      repeat (4) @(posedge clk);
      #1;
      check_eq("stb_count", stb_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < stb_q.size()) check_eq("stb_addr_data", {20'h0, stb_q[i]}, {20'h0, exp_q[i]});
      end
   endtask

   // Read n bytes; optionally set the pointer first (write phase + repeated START).
   task automatic txn_read(input bit set_ptr, input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      i2c_start();
      if (set_ptr) begin
         write_byte({SADR, 1'b0}, ack); check_eq("r_addrw_ack", {31'h0, ack}, 32'h0);
         write_byte(p, ack);            check_eq("r_ptr_ack", {31'h0, ack}, 32'h0);
         ptr_m = p % 16;
         i2c_start();
      end
      write_byte({SADR, 1'b1}, ack);    check_eq("r_addrr_ack", {31'h0, ack}, 32'h0);
      check_eq("busy_in_read", {31'h0, busy}, 32'h1);
      for (int i = 0; i < n; i++) begin
         read_byte((i == n - 1), d);
         check_eq("read_data", {24'h0, d}, {24'h0, mem[ptr_m]});
         ptr_m = (ptr_m + 1) % 16;
      end
      check_eq("busy_after_nack", {31'h0, busy}, 32'h0);
      i2c_stop();
   endtask

   initial begin
      logic       ack;
      logic [7:0] p;
      int         n;
      arst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_addr = 4'd0;
      hv_pend = 1'b0; oe_seen = 1'b0; busy_seen = 1'b0;
      hv_during = 8'h00; hv_after = 8'h00;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      ptr_m = 0;
      #3 arst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
      check_eq("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
      check_eq("rst_wr_data", {24'h0, wr_data}, 32'h0);
      check_regs("rst_regs");
      arst = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Single-byte write, watching host port at the same index.
      host_addr = 4'd1;
      wq = '{8'h0B};
      txn_write(8'h01);
      check_eq("host_old_during_stb", {24'h0, hv_during}, 32'h00);
      check_eq("host_new_after_stb", {24'h0, hv_after}, 32'h0B);
      check_regs("regs_t1");
      txn_read(1'b1, 8'h01, 1);

      // Foreign address: no ACK, no drive, no busy, no write.
      stb_q.delete();
      oe_seen = 1'b0; busy_seen = 1'b0;
      i2c_start();
      write_byte({7'h11, 1'b0}, ack); check_eq("foreign_nack", {31'h0, ack}, 32'h1);
      write_byte(8'h03, ack);         check_eq("foreign_ptr_nack", {31'h0, ack}, 32'h1);
      write_byte(8'h77, ack);
      i2c_stop();
      check_eq("foreign_oe", {31'h0, oe_seen}, 32'h0);
      check_eq("foreign_busy", {31'h0, busy_seen}, 32'h0);
      check_eq("foreign_stb", stb_q.size(), 32'h0);

      // Pointer wrap 15 -> 0.
      wq = '{8'hA5, 8'h5A};
      txn_write(8'h0F);
      check_regs("regs_wrap");
      txn_read(1'b1, 8'h0F, 2);

      // STOP after 5 data bits: byte discarded, pointer stays past the last full byte.
      p = 8'($urandom_range(0, 255));
      wq = '{8'($urandom_range(0, 255))};
      stb_q.delete(); exp_q.delete();
      i2c_start();
      write_byte({SADR, 1'b0}, ack);
      write_byte(p, ack);
      ptr_m = p % 16;
      write_byte(wq[0], ack);
      mem[ptr_m] = wq[0];
      ptr_m = (ptr_m + 1) % 16;
      for (int i = 0; i < 5; i++) write_bit(1'($urandom_range(0, 1)));
      i2c_stop();
      check_eq("abort_stb", stb_q.size(), 32'h1);
      check_regs("regs_abort");
      txn_read(1'b0, 8'h00, 1);

      // Randomized write/read mix.
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 4);
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
         txn_write(8'($urandom_range(0, 255)));
         txn_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
      end
      check_regs("regs_random");

      // Reset while the target drives the address ACK.
      i2c_start();
      for (int i = 7; i >= 0; i--) write_bit(((i == 0) ? 1'b0 : SADR[i - 1]));
      sda_m = 1'b1;
      wait_q();
      check_eq("ack_driven", {31'h0, sda_oe}, 32'h1);
      arst = 1'b0;
      #1;
      check_eq("rst_release_oe", {31'h0, sda_oe}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      arst = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      ptr_m = 0;
      scl_m = 1'b1; wait_q();
      scl_m = 1'b0; wait_q();
      i2c_stop();
      check_eq("busy_after_rst", {31'h0, busy}, 32'h0);
      check_regs("regs_after_rst");
      txn_read(1'b0, 8'h00, 1);
      wq = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      txn_write(8'h07);
      txn_read(1'b1, 8'h07, 2);
      check_regs("regs_final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
